// File: rtl/mem_line_reader_pkg.sv
// Shared types and constants for the memory read path.
// Used by the line reader FSM and its word register bank.
package mem_line_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int WORD_W_DEF = 32;
  localparam int BEATS_DEF  = 4;

  localparam int LINE_OFFSET_BITS =
    $clog2(BEATS_DEF * WORD_W_DEF / 8);

  function automatic int line_offset_bits(
    input int beats,
    input int word_w
  );
    return $clog2(beats * word_w / 8);
  endfunction

endpackage

// File: rtl/mem_line_reader_line_assembler.sv
// BEATS-entry word register bank with indexed write enable.
// Falling-edge update, asynchronous active-low clear.
module line_assembler
  import mem_line_reader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BEATS  = BEATS_DEF,
  parameter int IDX_W  = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic [WORD_W-1:0]       wdata,
  output logic [BEATS*WORD_W-1:0] line
);

  for (genvar i = 0; i < BEATS; i++) begin : g_word
    logic [WORD_W-1:0] word;

    always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
        word <= '0;
      end else if (we && idx == IDX_W'(i)) begin
        word <= wdata;
      end
    end

    assign line[i*WORD_W +: WORD_W] = word;
  end

endmodule

// File: rtl/mem_line_reader.sv
// Line read engine: one memory command per request, collects
// BEATS words, holds the line until acknowledged.
module mem_line_reader
  import mem_line_reader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int BEATS   = BEATS_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    busy,
  output logic                    line_valid,
  output logic [BEATS*WORD_W-1:0] line_data,
  input  logic                    line_ack,
  output logic                    err,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_valid,
  input  logic [WORD_W-1:0]       mem_data
);

  localparam int OFF   = line_offset_bits(BEATS, WORD_W);
  localparam int IDX_W = $clog2(BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] ALIGN =
    ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

  state_t            state, nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt;
  logic              err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              beat_we;

  always_comb begin
    nxt      = state;
    beat_nxt = beat_cnt;
    to_nxt   = to_cnt;
    err_nxt  = err;
    addr_nxt = mem_addr;
    beat_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          addr_nxt = rd_addr & ALIGN;
          err_nxt  = 1'b0;
          nxt      = ISSUE;
        end
      end
      ISSUE: begin
        beat_nxt = '0;
        to_nxt   = '0;
        nxt      = COLLECT;
      end
      COLLECT: begin
        if (mem_valid) begin
          beat_we  = 1'b1;
          beat_nxt = beat_cnt + CNT_W'(1);
          to_nxt   = '0;
          if (beat_cnt == CNT_W'(BEATS - 1)) begin
            nxt = DONE;
          end
        end else begin
          if (to_cnt != TO_W'(TIMEOUT)) begin
            to_nxt = to_cnt + TO_W'(1);
          end
          // this idle edge is the TIMEOUT-th in a row
          if (to_cnt >= TO_W'(TIMEOUT - 1)) begin
            err_nxt = 1'b1;
            nxt     = IDLE;
          end
        end
      end
      DONE: begin
        if (line_ack) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      to_cnt     <= '0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      line_valid <= 1'b0;
    end else begin
      state      <= nxt;
      beat_cnt   <= beat_nxt;
      to_cnt     <= to_nxt;
      err        <= err_nxt;
      mem_addr   <= addr_nxt;
      mem_req    <= (nxt == ISSUE);
      line_valid <= (nxt == DONE);
    end
  end

  assign busy = (state != IDLE);

  line_assembler #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS),
    .IDX_W  (IDX_W)
  ) u_asm (
    .clk   (clk),
    .reset (reset),
    .we    (beat_we),
    .idx   (beat_cnt[IDX_W-1:0]),
    .wdata (mem_data),
    .line  (line_data)
  );

endmodule

// File: tb/tb_mem_line_reader.sv
// Scoreboard bench for mem_line_reader.
// Inputs driven at posedge, outputs sampled at posedge.
module tb_mem_line_reader;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int NB = 4;
  localparam int TO = 8;
  localparam int LW = NB * WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          busy;
  logic          line_valid;
  logic [LW-1:0] line_data;
  logic          line_ack = 1'b0;
  logic          err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_valid = 1'b0;
  logic [WW-1:0] mem_data = '0;

  int compared = 0;
  int mismatched = 0;
  int mreq_cnt = 0;
  logic [LW-1:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) mreq_cnt++;

  mem_line_reader #(
    .ADDR_W  (AW),
    .WORD_W  (WW),
    .BEATS   (NB),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .line_valid (line_valid),
    .line_data  (line_data),
    .line_ack   (line_ack),
    .err        (err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data)
  );

  function automatic logic [LW-1:0] mk_line(
    input logic [WW-1:0] base
  );
    logic [LW-1:0] l;
    for (int i = 0; i < NB; i++) l[i*WW +: WW] = base + WW'(i);
    return l;
  endfunction

  task automatic start_req(input logic [AW-1:0] a);
    int n;
    n = 0;
    rd_req = 1'b1;
    rd_addr = a;
    do begin
      @(posedge clk);
      n++;
    end while (!busy && n < 20);
    rd_req = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL req_busy: busy=%b want 1", busy);
    end
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== (a & ~32'hF)) begin
      mismatched++;
      $display("FAIL issue: mem_req=%b addr=%h want 1 %h",
               mem_req, mem_addr, a & ~32'hF);
    end
    @(posedge clk);
    compared++;
    if (mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL req_pulse: mem_req=%b want 0", mem_req);
    end
  endtask

  task automatic send_beats(
    input logic [WW-1:0] base,
    input int n,
    input int gap
  );
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        mem_valid = 1'b0;
        mem_data = $urandom;
        @(posedge clk);
      end
      mem_valid = 1'b1;
      mem_data = base + WW'(i);
      @(posedge clk);
      mem_valid = 1'b0;
      mem_data = $urandom;
    end
  endtask

  task automatic expect_line(input int hold);
    logic [LW-1:0] exp;
    exp = '0;
    compared++;
    if (line_valid !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL line_valid: valid=%b err=%b want 1 0",
               line_valid, err);
    end
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard: got line %h want none",
               line_data);
    end else begin
      exp = exp_q.pop_front();
      if (line_data !== exp) begin
        mismatched++;
        $display("FAIL line_data: got %h want %h",
                 line_data, exp);
      end
    end
    repeat (hold) begin
      mem_valid = 1'b1;
      mem_data = $urandom;
      @(posedge clk);
    end
    mem_valid = 1'b0;
    if (hold > 0) begin
      compared++;
      if (line_valid !== 1'b1 || line_data !== exp) begin
        mismatched++;
        $display("FAIL line_hold: valid=%b data=%h want 1 %h",
                 line_valid, line_data, exp);
      end
    end
    line_ack = 1'b1;
    @(posedge clk);
    line_ack = 1'b0;
    compared++;
    if (line_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ack: valid=%b busy=%b want 0 0",
               line_valid, busy);
    end
  endtask

  task automatic test_reset();
    rd_req = 1'b1;
    mem_valid = 1'b1;
    repeat (2) @(posedge clk);
    compared++;
    if ({busy, line_valid, err, mem_req} !== 4'b0 ||
        mem_addr !== '0 || line_data !== '0) begin
      mismatched++;
      $display("FAIL reset: b%b v%b e%b r%b a%h d%h want 0",
               busy, line_valid, err, mem_req, mem_addr, line_data);
    end
    rd_req = 1'b0;
    mem_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_basic();
    int m0;
    m0 = mreq_cnt;
    exp_q.push_back(mk_line(32'hA0));
    start_req(32'h0000_1234);
    send_beats(32'hA0, NB, 0);
    expect_line(3);
    compared++;
    if (mreq_cnt - m0 != 1) begin
      mismatched++;
      $display("FAIL basic_mreq: got %0d pulses want 1",
               mreq_cnt - m0);
    end
  endtask

  task automatic test_gapped();
    exp_q.push_back(mk_line(32'hA0));
    start_req(32'h0000_ABCF);
    send_beats(32'hA0, NB - 1, 3);
    repeat (3) @(posedge clk);
    compared++;
    if (line_valid !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL gap_early: valid=%b err=%b want 0 0",
               line_valid, err);
    end
    send_beats(32'hA3, 1, 0);
    expect_line(0);
  endtask

  task automatic test_timeout();
    start_req(32'h0000_2000);
    send_beats(32'hC0, 2, 0);
    repeat (TO - 1) @(posedge clk);
    compared++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL to_early: err=%b busy=%b want 0 1", err, busy);
    end
    @(posedge clk);
    compared++;
    if (err !== 1'b1 || busy !== 1'b0 || line_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL to_fire: err=%b busy=%b valid=%b want 1 0 0",
               err, busy, line_valid);
    end
    repeat (3) @(posedge clk);
    compared++;
    if (err !== 1'b1 || line_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL to_sticky: err=%b valid=%b want 1 0",
               err, line_valid);
    end
    exp_q.push_back(mk_line(32'hC8));
    start_req(32'h0000_2010);
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL to_clear: err=%b want 0", err);
    end
    send_beats(32'hC8, NB, 1);
    expect_line(0);
  endtask

  task automatic test_reset_mid();
    start_req(32'h0000_3000);
    send_beats(32'hD0, 2, 0);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, line_valid, err, mem_req} !== 4'b0 ||
        mem_addr !== '0 || line_data !== '0) begin
      mismatched++;
      $display("FAIL rst_mid: b%b v%b e%b r%b a%h d%h want 0",
               busy, line_valid, err, mem_req, mem_addr, line_data);
    end
    @(posedge clk);
    rst_n = 1'b1;
    send_beats(32'hDD, 2, 0);
    @(posedge clk);
    compared++;
    if (busy !== 1'b0 || line_valid !== 1'b0 ||
        line_data !== '0) begin
      mismatched++;
      $display("FAIL stray: busy=%b valid=%b data=%h want 0",
               busy, line_valid, line_data);
    end
    exp_q.push_back(mk_line(32'hE0));
    start_req(32'h0000_3004);
    send_beats(32'hE0, NB, 0);
    expect_line(1);
  endtask

  task automatic test_busy_collision();
    int m0;
    m0 = mreq_cnt;
    exp_q.push_back(mk_line(32'hF0));
    start_req(32'h0000_4000);
    send_beats(32'hF0, 1, 0);
    rd_req = 1'b1;
    rd_addr = 32'h0000_9990;
    @(posedge clk);
    rd_req = 1'b0;
    send_beats(32'hF1, NB - 1, 0);
    expect_line(0);
    compared++;
    if (mreq_cnt - m0 != 1 || mem_addr !== 32'h0000_4000) begin
      mismatched++;
      $display("FAIL busy_req: pulses=%0d addr=%h want 1 4000",
               mreq_cnt - m0, mem_addr);
    end
  endtask

  task automatic test_ack_collision();
    logic [LW-1:0] exp;
    exp = mk_line(32'h10);
    start_req(32'h0000_5000);
    send_beats(32'h10, NB, 0);
    compared++;
    if (line_valid !== 1'b1 || line_data !== exp) begin
      mismatched++;
      $display("FAIL ac_line: valid=%b data=%h want 1 %h",
               line_valid, line_data, exp);
    end
    line_ack = 1'b1;
    rd_req = 1'b1;
    rd_addr = 32'h0000_6008;
    @(posedge clk);
    line_ack = 1'b0;
    compared++;
    if (line_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL ac_ack: valid=%b busy=%b req=%b want 0 0 0",
               line_valid, busy, mem_req);
    end
    @(posedge clk);
    rd_req = 1'b0;
    compared++;
    if (busy !== 1'b1 || mem_req !== 1'b1 ||
        mem_addr !== 32'h0000_6000) begin
      mismatched++;
      $display("FAIL ac_next: busy=%b req=%b addr=%h want 1 1 6000",
               busy, mem_req, mem_addr);
    end
    @(posedge clk);
    exp_q.push_back(mk_line(32'h20));
    send_beats(32'h20, NB, 0);
    expect_line(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_timeout();
    test_reset_mid();
    test_busy_collision();
    test_ack_collision();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: got %0d lines want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_line_reader.md
Name: mem_line_reader

Overview:
- Read side of the memory path. Accepts a line-read request from the cache controller and issues one read command to main memory.
- Collects BEATS sequential data words from memory and assembles them into one line.
- Holds the line for the requester until it is acknowledged.
- Counterpart to the write path that stores words into memory under a write enable.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, memory data beat width
BEATS, 4, words per line (power of two, >=2)
TIMEOUT, 255, max cycles waiting for any beat before error

Ports:
clk  in  1  clock; all state updates on falling edge, as for every storage element in the design
reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately
rd_req  in  1  requester: line read request, sampled in IDLE only
rd_addr  in  ADDR_W  requester: line address, captured with rd_req
busy  out  1  high in every state except IDLE
line_valid  out  1  assembled line available
line_data  out  BEATS*WORD_W  assembled line; word 0 in bits [WORD_W-1:0]
line_ack  in  1  requester consumes line
err  out  1  timeout flag, sticky until next accepted rd_req
mem_req  out  1  memory read command, one cycle pulse
mem_addr  out  ADDR_W  line-aligned address to memory
mem_valid  in  1  memory: beat valid
mem_data  in  WORD_W  memory: beat data

Behaviour:
- Reset (reset==0): state=IDLE; busy=0, line_valid=0, err=0, mem_req=0, mem_addr=0, line_data=0, beat counter=0, timeout counter=0.
- FSM states: IDLE, ISSUE, COLLECT, DONE.
- IDLE:
  - On rd_req=1: capture rd_addr with the low log2(BEATS*WORD_W/8) bits cleared, clear err, go to ISSUE.
  - mem_valid in IDLE is ignored.
- ISSUE:
  - mem_req=1 for exactly one cycle, with mem_addr = captured address.
  - Go to COLLECT; beat counter=0, timeout counter=0.
- COLLECT:
  - Each edge with mem_valid=1: write mem_data into word[beat counter], increment the counter, clear the timeout counter.
  - On the beat that makes the count equal BEATS: go to DONE.
  - Otherwise, with no beat: increment the timeout counter. When it reaches TIMEOUT: err=1, go to IDLE, line_valid stays 0, partial line discarded.
- DONE:
  - line_valid=1; line_data is stable and mem_valid is ignored.
  - On line_ack=1: line_valid=0, go to IDLE.
- line_ack outside DONE is ignored.
- rd_req outside IDLE is ignored (no queueing); the requester must hold rd_req until busy=1.
- Latency: rd_req seen at edge N gives mem_req at N+1 and line_valid one edge after the final beat. Minimum is rd_req to line_valid = BEATS+2 edges.
- line_ack and a new rd_req in the same cycle: ack is processed, and rd_req is not accepted until the next edge in IDLE.
- Reset asserted mid-operation: immediate return to reset state. A request in flight is abandoned, and late beats arriving in IDLE are ignored.
- Beat counter width is log2(BEATS) + 1, so there is no wrap-around inside a line. Timeout counter width is ceil(log2(TIMEOUT+1)), saturating.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, ISSUE=1, COLLECT=2, DONE=3)
  - default ADDR_W/WORD_W/BEATS
  - LINE_OFFSET_BITS constant
- One sub-module: line_assembler. It is a BEATS-entry word register bank with indexed write enable, async active-low clear and falling-edge update, built from per-word write-enabled registers.
- FSM and counters stay in mem_line_reader.

Test Plan:
- Basic read:
  - Stimulus: rd_req with rd_addr=0x0000_1234; memory returns 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
  - Required: mem_addr=0x0000_1230, exactly one mem_req pulse, line_data=0x000000A3_000000A2_000000A1_000000A0, line_valid held until line_ack.
- Gapped beats:
  - Stimulus: 3 idle cycles between each beat.
  - Required: same line assembled, err=0, line_valid one edge after beat 4.
- Timeout:
  - Stimulus: TIMEOUT=8; two beats, then none.
  - Required: err=1 after 8 idle cycles, line_valid never asserts, back to IDLE; next rd_req clears err.
- Reset mid-COLLECT:
  - Stimulus: reset=0 after beat 2, then reset=1, then 2 stray mem_valid beats.
  - Required: all outputs 0, state IDLE, stray beats ignored; the next read returns a correct line.
- Busy / ack collisions:
  - Stimulus: rd_req pulsed while in COLLECT.
  - Required: ignored, no second mem_req.
  - Stimulus: line_ack together with rd_req in DONE.
  - Required: line_valid drops; the new request is accepted only on the following edge.
